// File: rtl/alu_arbiter_if.sv
// Requester-side bus of alu_arbiter: two request/operand sets toward the
// arbiter, grant/completion/result back to the requesters.
interface alu_arbiter_if;
    logic [1:0] req_i;
    logic [3:0] op0_i;
    logic [3:0] op1_i;
    logic [3:0] a0_i;
    logic [3:0] a1_i;
    logic [3:0] b0_i;
    logic [3:0] b1_i;
    logic [1:0] sign_i;
    logic [1:0] gnt_o;
    logic [1:0] done_o;
    logic       err_o;
    logic [7:0] result_o;

    modport master (
        output req_i, op0_i, op1_i, a0_i, a1_i, b0_i, b1_i, sign_i,
        input  gnt_o, done_o, err_o, result_o
    );

    modport slave (
        input  req_i, op0_i, op1_i, a0_i, a1_i, b0_i, b1_i, sign_i,
        output gnt_o, done_o, err_o, result_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one multi-cycle ALU between the
// Controller (requester 0) and an auxiliary sequencer (requester 1).
module alu_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus,
    output logic [3:0]   alu_op_o,
    output logic [3:0]   alu_a_o,
    output logic [3:0]   alu_b_o,
    output logic         alu_sign_o,
    input  logic         alu_busy_i,
    input  logic [7:0]   alu_i
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [2:0] state;
    logic       winner;
    logic       last;
    logic       pick;
    logic [3:0] op_lat;
    logic [3:0] pick_op;
    logic [3:0] pick_a;
    logic [3:0] pick_b;
    logic       pick_sign;
    logic [7:0] wait_cnt;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       err;
    logic [7:0] result;
    logic [3:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_sign;
    logic [1:0] winner_onehot;

    // A tie goes to whichever requester was not served most recently.
    always_comb begin
        pick = 1'b0;
        case (bus.req_i)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            default: pick = ~last;
        endcase
    end

    assign pick_op       = pick ? bus.op1_i : bus.op0_i;
    assign pick_a        = pick ? bus.a1_i : bus.a0_i;
    assign pick_b        = pick ? bus.b1_i : bus.b0_i;
    assign pick_sign     = pick ? bus.sign_i[1] : bus.sign_i[0];
    assign winner_onehot = {winner, ~winner};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            winner   <= 1'b0;
            last     <= 1'b1;
            op_lat   <= 4'd0;
            wait_cnt <= 8'd0;
            gnt      <= 2'b00;
            done     <= 2'b00;
            err      <= 1'b0;
            result   <= 8'd0;
            alu_op   <= 4'd0;
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
            alu_sign <= 1'b0;
        end else begin
            done <= 2'b00;
            case (state)
                IDLE: begin
                    if (|bus.req_i) begin
                        winner   <= pick;
                        gnt      <= {pick, ~pick};
                        op_lat   <= pick_op;
                        alu_a    <= pick_a;
                        alu_b    <= pick_b;
                        alu_sign <= pick_sign;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_op <= op_lat;
                    state  <= SETTLE;
                end
                // The ALU's busy flag lags the opcode by a cycle, so it is not trusted yet.
                SETTLE: begin
                    wait_cnt <= 8'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (!alu_busy_i) begin
                        result <= alu_i;
                        err    <= 1'b0;
                        alu_op <= 4'd0;
                        done   <= winner_onehot;
                        state  <= DONE;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        result <= 8'd0;
                        err    <= 1'b1;
                        alu_op <= 4'd0;
                        done   <= winner_onehot;
                        state  <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    last  <= winner;
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.done_o   = done;
    assign bus.err_o    = err;
    assign bus.result_o = result;
    assign alu_op_o     = alu_op;
    assign alu_a_o      = alu_a;
    assign alu_b_o      = alu_b;
    assign alu_sign_o   = alu_sign;

    gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
    done_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(done));
    done_within_gnt: assert property (@(posedge clk) disable iff (!rst) (done & ~gnt) == 2'b00);
    done_no_op: assert property (@(posedge clk) disable iff (!rst) (done != 2'b00) |-> (alu_op == 4'd0));
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected completions,
// a monitor pops them whenever done_o pulses; a second instance covers timeout.
`timescale 1ns/1ps
module tb_alu_arbiter;
    typedef struct {
        logic [1:0] done;
        logic [7:0] result;
        logic       err;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();
    alu_arbiter_if tbus ();

    logic [3:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_sign;
    logic       alu_busy = 1'b0;
    logic [7:0] alu_res = 8'd0;
    logic [3:0] t_op;
    logic [3:0] t_a;
    logic [3:0] t_b;
    logic       t_sign;

    alu_arbiter dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sign_o(alu_sign),
        .alu_busy_i(alu_busy), .alu_i(alu_res)
    );

    alu_arbiter #(.TIMEOUT(4)) tdut (
        .clk(clk), .rst(rst), .bus(tbus),
        .alu_op_o(t_op), .alu_a_o(t_a), .alu_b_o(t_b), .alu_sign_o(t_sign),
        .alu_busy_i(1'b1), .alu_i(8'hAA)
    );

    exp_t sb_q[$];
    exp_t tsb_q[$];
    int   busy_q[$];
    exp_t mon_e;
    exp_t tmon_e;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'h1:    return {4'h0, a} + {4'h0, b};
            4'h3:    return {4'h0, a} * {4'h0, b};
            4'h4:    return {a, b};
            default: return {b, a};
        endcase
    endfunction

    // ALU model: busy for N WAIT cycles after the opcode appears, then presents the result.
    int   m_elapsed = 0;
    int   m_n = 0;
    logic m_active = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            m_active = 1'b0;
            alu_busy = 1'b0;
        end else if (m_active) begin
            if (alu_op == 4'd0) begin
                m_active = 1'b0;
            end else begin
                m_elapsed++;
                if (m_elapsed > m_n) begin
                    alu_busy = 1'b0;
                    alu_res  = alu_fn(alu_op, alu_a, alu_b);
                end
            end
        end else if (alu_op != 4'd0) begin
            m_n       = (busy_q.size() > 0) ? busy_q.pop_front() : 0;
            m_elapsed = 0;
            m_active  = 1'b1;
            if (m_n == 0) begin
                alu_busy = 1'b0;
                alu_res  = alu_fn(alu_op, alu_a, alu_b);
            end else begin
                alu_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && bus.done_o != 2'b00) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_done", 32'(bus.done_o), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_output("done", 32'(bus.done_o), 32'(mon_e.done));
                check_output("result", 32'(bus.result_o), 32'(mon_e.result));
                check_output("err", 32'(bus.err_o), 32'(mon_e.err));
                check_output("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && tbus.done_o != 2'b00) begin
            if (tsb_q.size() == 0) begin
                check_output("t_unexpected_done", 32'(tbus.done_o), 32'd0);
            end else begin
                tmon_e = tsb_q.pop_front();
                check_output("t_done", 32'(tbus.done_o), 32'(tmon_e.done));
                check_output("t_result", 32'(tbus.result_o), 32'(tmon_e.result));
                check_output("t_err", 32'(tbus.err_o), 32'(tmon_e.err));
                check_output("t_done_cycle", 32'(cyc), 32'(tmon_e.cyc));
            end
        end
    end

    // One request from a lone requester; its operands are scrambled in WAIT to prove isolation.
    task automatic apply_stimulus(input int idx, input logic [3:0] op, input logic [3:0] a,
                                  input logic [3:0] b, input logic sign, input int n,
                                  input logic [7:0] res);
        int s;
        logic [1:0] oh;
        oh = (idx == 1) ? 2'b10 : 2'b01;
        if (idx == 1) begin
            bus.op1_i = op; bus.a1_i = a; bus.b1_i = b;
        end else begin
            bus.op0_i = op; bus.a0_i = a; bus.b0_i = b;
        end
        bus.sign_i[idx] = sign;
        bus.req_i[idx]  = 1'b1;
        s = cyc;
        sb_q.push_back('{oh, res, 1'b0, s + 4 + n});
        if (op != 4'd0) busy_q.push_back(n);
        @(negedge clk);
        check_output("gnt", 32'(bus.gnt_o), 32'(oh));
        check_output("op_issue", 32'(alu_op), 32'd0);
        while (cyc < s + 4 + n) begin
            @(negedge clk);
            if (cyc == s + 3) begin
                if (idx == 1) begin
                    bus.op1_i = ~op; bus.a1_i = ~a; bus.b1_i = ~b;
                end else begin
                    bus.op0_i = ~op; bus.a0_i = ~a; bus.b0_i = ~b;
                end
                bus.sign_i[idx] = ~sign;
            end
            check_output("gnt_held", 32'(bus.gnt_o), 32'(oh));
            check_output("alu_op", 32'(alu_op), (cyc < s + 4 + n) ? 32'(op) : 32'd0);
            check_output("alu_a", 32'(alu_a), 32'(a));
            check_output("alu_b", 32'(alu_b), 32'(b));
            check_output("alu_sign", 32'(alu_sign), 32'(sign));
        end
        bus.req_i[idx] = 1'b0;
        @(negedge clk);
        check_output("gnt_clear", 32'(bus.gnt_o), 32'd0);
    endtask

    initial begin
        int s;
        bus.req_i = 2'b00; bus.sign_i = 2'b00;
        bus.op0_i = 4'd0; bus.op1_i = 4'd0; bus.a0_i = 4'd0; bus.a1_i = 4'd0;
        bus.b0_i = 4'd0; bus.b1_i = 4'd0;
        tbus.req_i = 2'b00; tbus.sign_i = 2'b00;
        tbus.op0_i = 4'd0; tbus.op1_i = 4'd0; tbus.a0_i = 4'd0; tbus.a1_i = 4'd0;
        tbus.b0_i = 4'd0; tbus.b1_i = 4'd0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_gnt", 32'(bus.gnt_o), 32'd0);
        check_output("rst_done", 32'(bus.done_o), 32'd0);
        check_output("rst_err", 32'(bus.err_o), 32'd0);
        check_output("rst_result", 32'(bus.result_o), 32'd0);
        check_output("rst_op", 32'(alu_op), 32'd0);
        check_output("t_rst_gnt", 32'(tbus.gnt_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] single request");
        apply_stimulus(0, 4'h1, 4'h3, 4'h5, 1'b1, 3, 8'h08);

        $display("[TB] input isolation on requester 1");
        apply_stimulus(1, 4'h1, 4'h6, 4'h2, 1'b0, 3, 8'h08);

        $display("[TB] tie and alternation");
        bus.op0_i = 4'h4; bus.a0_i = 4'h1; bus.b0_i = 4'h1;
        bus.op1_i = 4'h4; bus.a1_i = 4'h2; bus.b1_i = 4'h2;
        bus.req_i = 2'b11;
        s = cyc;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{((i % 2) == 1) ? 2'b10 : 2'b01,
                             ((i % 2) == 1) ? 8'h22 : 8'h11, 1'b0, s + 6 * i + 5});
            busy_q.push_back(1);
        end
        for (int i = 0; i < 4; i++) begin
            while (cyc < s + 6 * i + 1) @(negedge clk);
            check_output("tie_gnt", 32'(bus.gnt_o), ((i % 2) == 1) ? 32'd2 : 32'd1);
        end
        while (cyc < s + 23) @(negedge clk);
        bus.req_i = 2'b00;
        @(negedge clk);

        $display("[TB] early drop");
        bus.op1_i = 4'h4; bus.a1_i = 4'h3; bus.b1_i = 4'h7;
        bus.req_i = 2'b10;
        s = cyc;
        sb_q.push_back('{2'b10, 8'h37, 1'b0, s + 5});
        sb_q.push_back('{2'b01, 8'h0F, 1'b0, s + 10});
        busy_q.push_back(1);
        busy_q.push_back(0);
        @(negedge clk);
        check_output("drop_gnt1", 32'(bus.gnt_o), 32'd2);
        @(negedge clk);
        bus.req_i = 2'b01;
        bus.op0_i = 4'h1; bus.a0_i = 4'h9; bus.b0_i = 4'h6;
        while (cyc < s + 7) @(negedge clk);
        check_output("drop_gnt0", 32'(bus.gnt_o), 32'd1);
        while (cyc < s + 10) @(negedge clk);
        bus.req_i = 2'b00;
        @(negedge clk);

        $display("[TB] NOP opcode");
        apply_stimulus(0, 4'h0, 4'h5, 4'h5, 1'b0, 0, 8'h0F);

        $display("[TB] reset mid-WAIT");
        bus.op0_i = 4'h3; bus.a0_i = 4'h2; bus.b0_i = 4'h7;
        bus.req_i = 2'b01;
        s = cyc;
        busy_q.push_back(20);
        while (cyc < s + 4) @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("arst_gnt", 32'(bus.gnt_o), 32'd0);
        check_output("arst_done", 32'(bus.done_o), 32'd0);
        check_output("arst_err", 32'(bus.err_o), 32'd0);
        check_output("arst_result", 32'(bus.result_o), 32'd0);
        check_output("arst_op", 32'(alu_op), 32'd0);
        check_output("arst_a", 32'(alu_a), 32'd0);
        check_output("arst_b", 32'(alu_b), 32'd0);
        check_output("arst_sign", 32'(alu_sign), 32'd0);
        bus.req_i = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        apply_stimulus(0, 4'h3, 4'h2, 4'h7, 1'b0, 2, 8'h0E);

        $display("[TB] timeout");
        tbus.op0_i = 4'h5; tbus.a0_i = 4'h1; tbus.b0_i = 4'h2;
        tbus.req_i = 2'b01;
        s = cyc;
        tsb_q.push_back('{2'b01, 8'h00, 1'b1, s + 8});
        @(negedge clk);
        check_output("t_gnt", 32'(tbus.gnt_o), 32'd1);
        while (cyc < s + 5) @(negedge clk);
        check_output("t_op_wait", 32'(t_op), 32'd5);
        while (cyc < s + 8) @(negedge clk);
        tbus.req_i = 2'b00;
        @(negedge clk);
        check_output("t_op_after", 32'(t_op), 32'd0);
        check_output("t_err_held", 32'(tbus.err_o), 32'd1);
        check_output("t_result_held", 32'(tbus.result_o), 32'd0);
        check_output("t_gnt_clear", 32'(tbus.gnt_o), 32'd0);

        repeat (3) @(negedge clk);
        check_output("sb_empty", 32'(sb_q.size()), 32'd0);
        check_output("t_sb_empty", 32'(tsb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
